// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with optional return-address stack.
// Define PC_SEQ_RAS_EN to build the return-address stack in. Without it,
// call_en behaves as jump_en, ret_en holds and flags ras_unf, and the stack
// status outputs are tied off (ras_empty=1, ras_full=0, ras_ovf=0).
module pc_seq_unit #(
  parameter int unsigned           WIDTH        = 32,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = '0,
  parameter int unsigned           STEP         = 1,
  parameter int unsigned           RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc_en,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             stall,
  input  logic             clr_err,
  output logic [WIDTH-1:0] pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  // Circular storage: wr_ptr_q points at the next free slot, so a push while
  // full naturally overwrites the oldest entry once the pointer wraps.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_en;

  assign top_ptr = wr_ptr_q - PTR_W'(1);
`endif

  // Next-state selection following the fixed request priority.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
`ifdef PC_SEQ_RAS_EN
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    push_en  = 1'b0;
`endif
    if (!stall) begin
      // Clearing first lets an error raised this cycle override the clear.
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (ret_en) begin
`ifdef PC_SEQ_RAS_EN
        if (cnt_q != '0) begin
          pc_d     = ras_mem[top_ptr];
          wr_ptr_d = top_ptr;
          cnt_d    = cnt_q - (PTR_W + 1)'(1);
        end else begin
          unf_d = 1'b1;
        end
`else
        unf_d = 1'b1;
`endif
      end else if (call_en) begin
        pc_d = jump_addr;
`ifdef PC_SEQ_RAS_EN
        push_en  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (cnt_q == DEPTH_C) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + (PTR_W + 1)'(1);
        end
`endif
      end else if (jump_en) begin
        pc_d = jump_addr;
      end else if (branch_en) begin
        pc_d = pc_q + branch_off;
      end else if (inc_en) begin
        pc_d = pc_q + STEP_W;
      end
    end
  end

  // Architectural state with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef PC_SEQ_RAS_EN
      wr_ptr_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef PC_SEQ_RAS_EN
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Stack storage carries no reset; contents are meaningless once count is 0.
  always_ff @(posedge clock) begin
    if (push_en) begin
      ras_mem[wr_ptr_q] <= pc_q + STEP_W;
    end
  end

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == DEPTH_C);
  assign ras_ovf   = ovf_q;
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
`endif

  assign pc_out  = pc_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed and random stimulus for pc_seq_unit, checked
// against a queue-based reference model. Honours PC_SEQ_RAS_EN like the DUT.
module tb_pc_seq_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inc_en, jump_en, branch_en, call_en, ret_en, stall, clr_err;
  logic [31:0] jump_addr, branch_off;
  logic [31:0] pc_out;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  pc_seq_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .STEP(1), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .inc_en(inc_en), .jump_en(jump_en), .jump_addr(jump_addr),
    .branch_en(branch_en), .branch_off(branch_off),
    .call_en(call_en), .ret_en(ret_en), .stall(stall), .clr_err(clr_err),
    .pc_out(pc_out), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_ovf, m_unf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of architectural behaviour, from the request rules directly.
  task automatic model_step();
    logic e_ovf, e_unf;
    if (stall) return;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    if (ret_en) begin
`ifdef PC_SEQ_RAS_EN
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else e_unf = 1'b1;
`else
      e_unf = 1'b1;
`endif
    end else if (call_en) begin
`ifdef PC_SEQ_RAS_EN
      m_stack.push_back(m_pc + 32'd1);
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        e_ovf = 1'b1;
      end
`endif
      m_pc = jump_addr;
    end else if (jump_en)   m_pc = jump_addr;
    else if (branch_en)     m_pc = m_pc + branch_off;
    else if (inc_en)        m_pc = m_pc + 32'd1;
    if (clr_err) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (e_ovf) m_ovf = 1'b1;
    if (e_unf) m_unf = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"},    pc_out,           m_pc);
    chk({tag, ".empty"}, 32'(ras_empty),   32'(m_stack.size() == 0));
    chk({tag, ".full"},  32'(ras_full),    32'(m_stack.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ras_ovf),     32'(m_ovf));
    chk({tag, ".unf"},   32'(ras_unf),     32'(m_unf));
  endtask

  task automatic drive(input logic st, input logic rt, input logic cl, input logic jp,
                       input logic br, input logic ic, input logic clr,
                       input logic [31:0] ja, input logic [31:0] bo);
    stall = st; ret_en = rt; call_en = cl; jump_en = jp;
    branch_en = br; inc_en = ic; clr_err = clr;
    jump_addr = ja; branch_off = bo;
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_step();
    #1;
    n_txn++;
    $display("txn %0d %s: st=%b rt=%b cl=%b jp=%b br=%b ic=%b clr=%b ja=%h bo=%h -> pc=%h e=%b f=%b o=%b u=%b",
             n_txn, tag, stall, ret_en, call_en, jump_en, branch_en, inc_en, clr_err,
             jump_addr, branch_off, pc_out, ras_empty, ras_full, ras_ovf, ras_unf);
    compare_all(tag);
  endtask

  task automatic op(input string tag, input logic st, input logic rt, input logic cl,
                    input logic jp, input logic br, input logic ic, input logic clr,
                    input logic [31:0] ja, input logic [31:0] bo);
    drive(st, rt, cl, jp, br, ic, clr, ja, bo);
    cycle(tag);
  endtask

  // Reset asserted away from the clock edge, checked before the next edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    model_reset();
    #3;
    compare_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Sequential advance from the reset vector, then a mid-cycle reset.
    for (int i = 0; i < 3; i++) op("inc", 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("inc3_literal", pc_out, 32'h3);
    op("inc_pre_rst", 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    async_reset("async_rst");
    chk("async_rst_literal", pc_out, 32'h0);

    // Wrap at the top of the address space.
    op("jmp_top", 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0);
    op("inc_wrap", 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    chk("wrap_literal", pc_out, 32'h0);

    // Negative branch, and jump beating branch.
    op("jmp_100", 0, 0, 0, 1, 0, 0, 0, 32'h100, 32'h0);
    op("br_neg", 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFF0);
    chk("br_neg_literal", pc_out, 32'h0F0);
    op("jmp_over_br", 0, 0, 0, 1, 1, 1, 0, 32'h40, 32'h1234);
    chk("jmp_prio_literal", pc_out, 32'h40);

    // Call, return, underflow, clear.
    op("jmp_10", 0, 0, 0, 1, 0, 0, 0, 32'h10, 32'h0);
    op("call_80", 0, 0, 1, 1, 1, 1, 0, 32'h80, 32'h0);
    op("ret", 0, 1, 1, 0, 0, 1, 0, 32'h999, 32'h0);
    op("ret_empty", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("unf_literal", 32'(ras_unf), 32'h1);
    op("clr", 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    chk("unf_clr_literal", 32'(ras_unf), 32'h0);

    // Overflowing calls, then draining returns.
    async_reset("rst2");
    op("jmp_1", 0, 0, 0, 1, 0, 0, 0, 32'h1, 32'h0);
    for (int i = 0; i < 5; i++) op("call_chain", 0, 0, 1, 0, 0, 0, 0, 32'(i + 2), 32'h0);
    for (int i = 0; i < 5; i++) op("ret_chain", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Stall freezes everything, including the error clear.
    op("call_pre_stall", 0, 0, 1, 0, 0, 0, 0, 32'h200, 32'h0);
    op("ret_err", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    op("ret_err2", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    op("stall", 1, 0, 1, 0, 0, 1, 1, 32'h300, 32'h0);
    op("stall_ret", 1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    // Error in the same cycle as clear keeps the flag set.
    op("clr_and_unf", 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom(), $urandom());
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
